// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Execute-stage branch/jump resolution for the RV32I core: evaluates the
// condition and target for conditional branches, JAL and JALR, produces the
// link value, detects mispredicts against the fetch prediction, and owns a
// 2-bit saturating branch history table read combinationally by fetch.
// Results pass through one registered valid/ready output stage.
// Optional feature macro: BRU_PERF_CNT_EN (adds branch/mispredict counters).

module branch_resolve_unit #(
  parameter  int XLEN      = 32,
  parameter  int BHT_DEPTH = 64,
  localparam int BHT_IDX_W = $clog2(BHT_DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_opA,
  input  logic [XLEN-1:0] i_opB,
  input  logic [XLEN-1:0] i_offset,
  input  logic [XLEN-1:0] i_pc,
  input  logic [2:0]      i_instr_type,
  input  logic            i_pred_taken,
  input  logic [XLEN-1:0] i_pred_target,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_jump,
  output logic [XLEN-1:0] o_target,
  output logic [XLEN-1:0] o_link,
  output logic            o_wr_en,
  output logic            o_mispredict,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_misalign,
  input  logic [XLEN-1:0] i_lookup_pc,
  output logic            o_pred_taken
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]     o_br_cnt,
  output logic [31:0]     o_mispred_cnt
`endif
);

  typedef enum logic [2:0] {
    OP_BEQ  = 3'd0,
    OP_BNE  = 3'd1,
    OP_BLT  = 3'd2,
    OP_BLTU = 3'd3,
    OP_BGE  = 3'd4,
    OP_BGEU = 3'd5,
    OP_JALR = 3'd6,
    OP_JAL  = 3'd7
  } instr_type_e;

  instr_type_e op_type;
  logic        accept;
  logic        is_cond;

  logic [XLEN-1:0] pc_rel_sum;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] link;

  logic            taken;
  logic [XLEN-1:0] target;
  logic            misalign;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic            wr_en;

  logic            valid_q,       valid_d;
  logic            jump_q,        jump_d;
  logic [XLEN-1:0] target_q,      target_d;
  logic [XLEN-1:0] link_q,        link_d;
  logic            wr_en_q,       wr_en_d;
  logic            mispredict_q,  mispredict_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            misalign_q,    misalign_d;

  logic [1:0]           bht_q [BHT_DEPTH];
  logic [1:0]           bht_d [BHT_DEPTH];
  logic [BHT_IDX_W-1:0] upd_idx;
  logic [BHT_IDX_W-1:0] lookup_idx;

  logic unused_bits;

  assign op_type    = instr_type_e'(i_instr_type);
  assign is_cond    = (i_instr_type < 3'd6);
  assign o_ready    = !valid_q || i_ready;
  assign accept     = i_valid && o_ready;

  assign pc_rel_sum = i_pc + i_offset;
  assign jalr_sum   = i_opA + i_offset;
  assign link       = i_pc + XLEN'(4);

  assign upd_idx    = i_pc[BHT_IDX_W+1:2];
  assign lookup_idx = i_lookup_pc[BHT_IDX_W+1:2];

  // Bits that never influence any result are gathered here so they are visibly ignored.
  assign unused_bits = ^{jalr_sum[0], i_lookup_pc[XLEN-1:BHT_IDX_W+2], i_lookup_pc[1:0]};

  // Resolve condition, target, alignment and mispredict for the offered operation.
  always_comb begin
    taken = 1'b0;
    case (op_type)
      OP_BEQ:  taken = (i_opA == i_opB);
      OP_BNE:  taken = (i_opA != i_opB);
      OP_BLT:  taken = ($signed(i_opA) <  $signed(i_opB));
      OP_BLTU: taken = (i_opA <  i_opB);
      OP_BGE:  taken = ($signed(i_opA) >= $signed(i_opB));
      OP_BGEU: taken = (i_opA >= i_opB);
      OP_JALR: taken = 1'b1;
      OP_JAL:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    target      = (op_type == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc_rel_sum;
    misalign    = taken && target[1];
    mispredict  = !misalign &&
                  ((taken != i_pred_taken) || (taken && (i_pred_target != target)));
    redirect_pc = taken ? target : link;
    wr_en       = !is_cond && !misalign;
  end

  // Output stage next state: load on accept, drop valid once the result is taken.
  always_comb begin
    valid_d       = valid_q;
    jump_d        = jump_q;
    target_d      = target_q;
    link_d        = link_q;
    wr_en_d       = wr_en_q;
    mispredict_d  = mispredict_q;
    redirect_pc_d = redirect_pc_q;
    misalign_d    = misalign_q;
    if (accept) begin
      valid_d       = 1'b1;
      jump_d        = taken;
      target_d      = target;
      link_d        = link;
      wr_en_d       = wr_en;
      mispredict_d  = mispredict;
      redirect_pc_d = redirect_pc;
      misalign_d    = misalign;
    end else if (i_ready) begin
      valid_d       = 1'b0;
    end
  end

  // Output stage registers; reset clears everything and discards a pending result.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      valid_q       <= 1'b0;
      jump_q        <= 1'b0;
      target_q      <= '0;
      link_q        <= '0;
      wr_en_q       <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      misalign_q    <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      jump_q        <= jump_d;
      target_q      <= target_d;
      link_q        <= link_d;
      wr_en_q       <= wr_en_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
      misalign_q    <= misalign_d;
    end
  end

  // BHT next state: saturating train of the indexed counter on accepted conditional branches.
  always_comb begin
    bht_d = bht_q;
    if (accept && is_cond) begin
      if (taken) begin
        if (bht_q[upd_idx] != 2'b11) bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
      end else begin
        if (bht_q[upd_idx] != 2'b00) bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
      end
    end
  end

  // BHT storage; every counter restarts weakly not-taken.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
    end else begin
      bht_q <= bht_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_jump        = jump_q;
  assign o_target      = target_q;
  assign o_link        = link_q;
  assign o_wr_en       = wr_en_q;
  assign o_mispredict  = mispredict_q;
  assign o_redirect_pc = redirect_pc_q;
  assign o_misalign    = misalign_q;

  // The lookup reads the registered table, so a same-cycle update is not visible yet.
  assign o_pred_taken  = bht_q[lookup_idx][1];

`ifdef BRU_PERF_CNT_EN
  logic [31:0] br_cnt_q,      br_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // Count completed result handshakes and the mispredicting subset.
  always_comb begin
    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (valid_q && i_ready) begin
      br_cnt_d = br_cnt_q + 32'd1;
      if (mispredict_q) mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  // Counter registers, free-running with natural wrap.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_br_cnt      = br_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit
// Directed, table-driven bench for branch_resolve_unit with hand-written
// sequences for backpressure, BHT saturation/no-bypass and mid-operation reset.
// Honours BRU_PERF_CNT_EN when defined.

module tb_branch_resolve_unit;

  logic        clk;
  logic        i_rstn;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_opA;
  logic [31:0] i_opB;
  logic [31:0] i_offset;
  logic [31:0] i_pc;
  logic [2:0]  i_instr_type;
  logic        i_pred_taken;
  logic [31:0] i_pred_target;
  logic        o_valid;
  logic        i_ready;
  logic        o_jump;
  logic [31:0] o_target;
  logic [31:0] o_link;
  logic        o_wr_en;
  logic        o_mispredict;
  logic [31:0] o_redirect_pc;
  logic        o_misalign;
  logic [31:0] i_lookup_pc;
  logic        o_pred_taken;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] o_br_cnt;
  logic [31:0] o_mispred_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;
  int hs_cnt     = 0;

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] off;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        jump;
    logic [31:0] tgt;
    logic [31:0] link;
    logic        wr;
    logic        misp;
    logic [31:0] redir;
    logic        mis;
    logic        bht;
  } vec_t;

  vec_t vecs [16];

  branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(64)) dut (
    .i_clk         (clk),
    .i_rstn        (i_rstn),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_opA         (i_opA),
    .i_opB         (i_opB),
    .i_offset      (i_offset),
    .i_pc          (i_pc),
    .i_instr_type  (i_instr_type),
    .i_pred_taken  (i_pred_taken),
    .i_pred_target (i_pred_target),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_jump        (o_jump),
    .o_target      (o_target),
    .o_link        (o_link),
    .o_wr_en       (o_wr_en),
    .o_mispredict  (o_mispredict),
    .o_redirect_pc (o_redirect_pc),
    .o_misalign    (o_misalign),
    .i_lookup_pc   (i_lookup_pc),
    .o_pred_taken  (o_pred_taken)
`ifdef BRU_PERF_CNT_EN
    ,
    .o_br_cnt      (o_br_cnt),
    .o_mispred_cnt (o_mispred_cnt)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe result handshakes independently so lost or duplicated ops show up.
  always @(posedge clk) begin
    if (i_rstn && o_valid && i_ready) hs_cnt++;
  end

  function automatic vec_t mkVec(
    input logic [2:0] typ, input logic [31:0] opa, input logic [31:0] opb,
    input logic [31:0] off, input logic [31:0] pc, input logic pt,
    input logic [31:0] ptgt, input logic jump, input logic [31:0] tgt,
    input logic [31:0] link, input logic wr, input logic misp,
    input logic [31:0] redir, input logic mis, input logic bht);
    vec_t v;
    v.typ = typ; v.opa = opa; v.opb = opb; v.off = off; v.pc = pc;
    v.pt = pt; v.ptgt = ptgt; v.jump = jump; v.tgt = tgt; v.link = link;
    v.wr = wr; v.misp = misp; v.redir = redir; v.mis = mis; v.bht = bht;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic driveOp(input logic [2:0] typ, input logic [31:0] opa, input logic [31:0] opb,
                         input logic [31:0] off, input logic [31:0] pc, input logic pt,
                         input logic [31:0] ptgt);
    i_instr_type  = typ;
    i_opA         = opa;
    i_opB         = opb;
    i_offset      = off;
    i_pc          = pc;
    i_pred_taken  = pt;
    i_pred_target = ptgt;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    driveOp(v.typ, v.opa, v.opb, v.off, v.pc, v.pt, v.ptgt);
    i_lookup_pc = v.pc;
    i_ready     = 1'b1;
    i_valid     = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  initial begin
    i_rstn = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    driveOp(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    i_lookup_pc = 32'h100;

    // typ opa opb off pc pt ptgt | jump tgt link wr misp redir mis bht
    vecs[0]  = mkVec(3'd0, 32'h5, 32'h5, 32'h20, 32'h100, 1'b0, 32'h0,
                     1'b1, 32'h120, 32'h104, 1'b0, 1'b1, 32'h120, 1'b0, 1'b1);
    vecs[1]  = mkVec(3'd0, 32'h5, 32'h5, 32'h20, 32'h100, 1'b0, 32'h0,
                     1'b1, 32'h120, 32'h104, 1'b0, 1'b1, 32'h120, 1'b0, 1'b1);
    vecs[2]  = mkVec(3'd1, 32'h5, 32'h5, 32'h20, 32'h100, 1'b1, 32'h120,
                     1'b0, 32'h120, 32'h104, 1'b0, 1'b1, 32'h104, 1'b0, 1'b1);
    vecs[3]  = mkVec(3'd2, 32'hFFFFFFFF, 32'h1, 32'h40, 32'h200, 1'b0, 32'h0,
                     1'b1, 32'h240, 32'h204, 1'b0, 1'b1, 32'h240, 1'b0, 1'b1);
    vecs[4]  = mkVec(3'd3, 32'hFFFFFFFF, 32'h1, 32'h40, 32'h200, 1'b0, 32'h0,
                     1'b0, 32'h240, 32'h204, 1'b0, 1'b0, 32'h204, 1'b0, 1'b1);
    vecs[5]  = mkVec(3'd6, 32'h1003, 32'h0, 32'h0, 32'h300, 1'b1, 32'h1002,
                     1'b1, 32'h1002, 32'h304, 1'b0, 1'b0, 32'h1002, 1'b1, 1'b1);
    vecs[6]  = mkVec(3'd6, 32'h1005, 32'h0, 32'hFFFFFFFF, 32'h304, 1'b1, 32'h1004,
                     1'b1, 32'h1004, 32'h308, 1'b1, 1'b0, 32'h1004, 1'b0, 1'b0);
    vecs[7]  = mkVec(3'd6, 32'h2001, 32'h0, 32'h10, 32'h308, 1'b1, 32'h2014,
                     1'b1, 32'h2010, 32'h30C, 1'b1, 1'b1, 32'h2010, 1'b0, 1'b0);
    vecs[8]  = mkVec(3'd7, 32'h0, 32'h0, 32'h6, 32'h400, 1'b0, 32'h0,
                     1'b1, 32'h406, 32'h404, 1'b0, 1'b0, 32'h406, 1'b1, 1'b1);
    vecs[9]  = mkVec(3'd7, 32'h0, 32'h0, 32'h10, 32'h40C, 1'b1, 32'h41C,
                     1'b1, 32'h41C, 32'h410, 1'b1, 1'b0, 32'h41C, 1'b0, 1'b0);
    vecs[10] = mkVec(3'd4, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFF0, 32'h20, 1'b1, 32'h10,
                     1'b1, 32'h10, 32'h24, 1'b0, 1'b0, 32'h10, 1'b0, 1'b1);
    vecs[11] = mkVec(3'd5, 32'h1, 32'hFFFFFFFF, 32'h8, 32'h24, 1'b1, 32'h2C,
                     1'b0, 32'h2C, 32'h28, 1'b0, 1'b1, 32'h28, 1'b0, 1'b0);
    vecs[12] = mkVec(3'd0, 32'h3, 32'h3, 32'h8, 32'hFFFFFFFC, 1'b0, 32'h0,
                     1'b1, 32'h4, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0, 1'b1);
    vecs[13] = mkVec(3'd1, 32'h7, 32'h8, 32'h100, 32'h44, 1'b1, 32'h148,
                     1'b1, 32'h144, 32'h48, 1'b0, 1'b1, 32'h144, 1'b0, 1'b1);
    vecs[14] = mkVec(3'd2, 32'h5, 32'h80000000, 32'h10, 32'h48, 1'b0, 32'h0,
                     1'b0, 32'h58, 32'h4C, 1'b0, 1'b0, 32'h4C, 1'b0, 1'b0);
    vecs[15] = mkVec(3'd0, 32'h0, 32'h0, 32'h2, 32'h50, 1'b0, 32'h0,
                     1'b1, 32'h52, 32'h54, 1'b0, 1'b0, 32'h52, 1'b1, 1'b1);

    // Reset state: everything cleared, table weakly not-taken.
    repeat (2) @(posedge clk);
    #1;
    i_rstn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst.valid",    o_valid,       32'h0);
    checkOutput("rst.ready",    o_ready,       32'h1);
    checkOutput("rst.jump",     o_jump,        32'h0);
    checkOutput("rst.target",   o_target,      32'h0);
    checkOutput("rst.link",     o_link,        32'h0);
    checkOutput("rst.wr_en",    o_wr_en,       32'h0);
    checkOutput("rst.misp",     o_mispredict,  32'h0);
    checkOutput("rst.redirect", o_redirect_pc, 32'h0);
    checkOutput("rst.misalign", o_misalign,    32'h0);
    for (int k = 0; k < 4; k++) begin
      i_lookup_pc = 32'h100 + 32'(k) * 32'h44;
      #1;
      checkOutput($sformatf("rst.pred%0d", k), o_pred_taken, 32'h0);
    end

    // Table of single operations with full-rate result acceptance.
    for (int n = 0; n < 16; n++) begin
      applyStimulus(vecs[n]);
      checkOutput($sformatf("v%0d.valid", n),    o_valid,       32'h1);
      checkOutput($sformatf("v%0d.jump", n),     o_jump,        32'(vecs[n].jump));
      checkOutput($sformatf("v%0d.target", n),   o_target,      vecs[n].tgt);
      checkOutput($sformatf("v%0d.link", n),     o_link,        vecs[n].link);
      checkOutput($sformatf("v%0d.wr_en", n),    o_wr_en,       32'(vecs[n].wr));
      checkOutput($sformatf("v%0d.misp", n),     o_mispredict,  32'(vecs[n].misp));
      checkOutput($sformatf("v%0d.redirect", n), o_redirect_pc, vecs[n].redir);
      checkOutput($sformatf("v%0d.misalign", n), o_misalign,    32'(vecs[n].mis));
      checkOutput($sformatf("v%0d.bht", n),      o_pred_taken,  32'(vecs[n].bht));
    end
    @(posedge clk);
    #1;
    checkOutput("tbl.valid_fall", o_valid, 32'h0);
    checkOutput("tbl.handshakes", 32'(hs_cnt), 32'd16);
`ifdef BRU_PERF_CNT_EN
    checkOutput("perf.br_cnt",      o_br_cnt,      32'd16);
    checkOutput("perf.mispred_cnt", o_mispred_cnt, 32'd8);
`endif

    // Backpressure: first op held, second op waits until the result drains.
    begin
      int hs0;
      hs0 = hs_cnt;
      @(negedge clk);
      i_ready = 1'b0;
      driveOp(3'd0, 32'h9, 32'h9, 32'h10, 32'h500, 1'b1, 32'h510);
      i_valid = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp.valid_a",  o_valid,  32'h1);
      checkOutput("bp.target_a", o_target, 32'h510);
      checkOutput("bp.ready_a",  o_ready,  32'h0);
      driveOp(3'd7, 32'h0, 32'h0, 32'h20, 32'h600, 1'b1, 32'h620);
      for (int k = 0; k < 2; k++) begin
        @(posedge clk);
        #1;
        checkOutput($sformatf("bp.hold%0d.valid", k),  o_valid,  32'h1);
        checkOutput($sformatf("bp.hold%0d.target", k), o_target, 32'h510);
        checkOutput($sformatf("bp.hold%0d.link", k),   o_link,   32'h504);
        checkOutput($sformatf("bp.hold%0d.ready", k),  o_ready,  32'h0);
      end
      @(negedge clk);
      i_ready = 1'b1;
      #1;
      checkOutput("bp.ready_up", o_ready, 32'h1);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      checkOutput("bp.valid_b",  o_valid,  32'h1);
      checkOutput("bp.target_b", o_target, 32'h620);
      checkOutput("bp.link_b",   o_link,   32'h604);
      checkOutput("bp.wr_en_b",  o_wr_en,  32'h1);
      @(posedge clk);
      #1;
      checkOutput("bp.valid_end", o_valid, 32'h0);
      checkOutput("bp.hs_count",  32'(hs_cnt - hs0), 32'd2);
    end

    // No bypass: the update-cycle lookup shows the old counter, then the new one.
    @(negedge clk);
    driveOp(3'd0, 32'h1, 32'h1, 32'h8, 32'hC0, 1'b1, 32'hC8);
    i_lookup_pc = 32'hC0;
    i_valid = 1'b1;
    #1;
    checkOutput("byp.pre", o_pred_taken, 32'h0);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    checkOutput("byp.post", o_pred_taken, 32'h1);

    // Saturate low: four not-taken then one taken at 0x80 stays predicted not-taken.
    i_lookup_pc = 32'h80;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      driveOp((k < 4) ? 3'd0 : 3'd1, 32'h1, 32'h2, 32'h8, 32'h80, 1'b0, 32'h0);
      i_valid = 1'b1;
      #1;
      checkOutput($sformatf("sat%0d.pre", k), o_pred_taken, 32'h0);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      checkOutput($sformatf("sat%0d.post", k), o_pred_taken, 32'h0);
    end

    // Reset mid-operation, with an accept and a BHT update offered at the reset edge.
    @(negedge clk);
    i_ready = 1'b0;
    driveOp(3'd0, 32'h4, 32'h4, 32'h4, 32'hC0, 1'b1, 32'hC4);
    i_lookup_pc = 32'hC0;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rmid.valid_pre", o_valid, 32'h1);
    @(negedge clk);
    i_ready = 1'b1;
    i_rstn  = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rmid.valid",  o_valid,  32'h0);
    checkOutput("rmid.jump",   o_jump,   32'h0);
    checkOutput("rmid.target", o_target, 32'h0);
    checkOutput("rmid.link",   o_link,   32'h0);
    checkOutput("rmid.bht",    o_pred_taken, 32'h0);
    @(negedge clk);
    i_rstn  = 1'b1;
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rmid.no_pulse", o_valid, 32'h0);
    i_lookup_pc = 32'h100;
    #1;
    checkOutput("rmid.bht100", o_pred_taken, 32'h0);
`ifdef BRU_PERF_CNT_EN
    checkOutput("rmid.br_cnt", o_br_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
